// File: rtl/crc32_pkg.sv
// Shared CRC32 constants, checker state encoding and the word-wide LFSR step
// (polynomial 0x04C11DB7, MSB first, no reflection, no final XOR).
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_BODY,
    CHK_FLUSH,
    CHK_DROP
  } chk_state_e;

  // Absorb one word: XOR it in, then clock the Galois LFSR 32 times with zero input.
  function automatic logic [31:0] crc32_step(input logic [31:0] state,
                                             input logic [31:0] data);
    logic [31:0] s;
    s = state ^ data;
    for (int i = 0; i < 32; i++) begin
      s = s[31] ? ((s << 1) ^ CRC32_POLY) : (s << 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/crc32_frame_checker_step.sv
// Registered word-wide CRC32 LFSR; init has priority over enable.
module crc32_word_step
  import crc32_pkg::*;
#(
  parameter logic [31:0] INIT = CRC32_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else if (init_i) begin
      crc_q <= INIT;
    end else if (en_i) begin
      crc_q <= crc32_step(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC32 frame checker: strips the trailer word, moves m_last onto the
// final payload word and strobes per-frame status. Macro CRC32_FRAME_STATS_EN adds frame/error counters.
//
// state     | meaning
// CHK_IDLE  | between frames, hold empty, word count zero
// CHK_BODY  | inside a frame, one payload word held back
// CHK_FLUSH | MAX_WORDS reached, presenting held word as last
// CHK_DROP  | discarding input up to and including s_last
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter logic [31:0] CRC_INIT  = CRC32_INIT,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        stat_valid,
  output logic        stat_crc_ok,
  output logic        stat_overrun,
  output logic [31:0] stat_crc_recv,
  output logic [31:0] stat_crc_calc
`ifdef CRC32_FRAME_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
`endif
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  chk_state_e  state_q;
  logic        hv_q;
  logic [31:0] hd_q;
  logic [CW-1:0] wcnt_q;
  logic        stat_valid_q, stat_ok_q, stat_ov_q;
  logic [31:0] stat_recv_q, stat_calc_q;

  logic [31:0] crc_cur;
  logic        in_frame, acc, pay_acc, trl_acc, drop_end, hit_max;
  logic        stat_evt, stat_ok_d;

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    unique case (state_q)
      CHK_IDLE, CHK_BODY: begin
        s_ready = ~hv_q | m_ready;
        m_valid = hv_q & s_valid;
        m_last  = s_last;
      end
      CHK_FLUSH: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
      end
      CHK_DROP: s_ready = 1'b1;
      default: ;
    endcase
  end

  assign m_data    = hd_q;
  assign in_frame  = (state_q == CHK_IDLE) | (state_q == CHK_BODY);
  assign acc       = s_valid & s_ready;
  assign pay_acc   = acc & ~s_last & in_frame;
  assign trl_acc   = acc & s_last & in_frame;
  assign drop_end  = acc & s_last & (state_q == CHK_DROP);
  assign hit_max   = (wcnt_q == CW'(MAX_WORDS - 1));
  assign stat_evt  = trl_acc | drop_end;
  assign stat_ok_d = trl_acc & (s_data == crc_cur);

  crc32_word_step #(.INIT(CRC_INIT)) u_step (
    .clk   (clk),
    .rst   (rst),
    .init_i(stat_evt),
    .en_i  (pay_acc),
    .data_i(s_data),
    .crc_o (crc_cur)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CHK_IDLE;
      hv_q         <= 1'b0;
      hd_q         <= '0;
      wcnt_q       <= '0;
      stat_valid_q <= 1'b0;
      stat_ok_q    <= 1'b0;
      stat_ov_q    <= 1'b0;
      stat_recv_q  <= '0;
      stat_calc_q  <= '0;
    end else begin
      stat_valid_q <= 1'b0;
      if (stat_evt) begin
        // An overrun frame reports the CRC frozen at MAX_WORDS against its own trailer.
        stat_valid_q <= 1'b1;
        stat_ok_q    <= stat_ok_d;
        stat_ov_q    <= drop_end;
        stat_recv_q  <= s_data;
        stat_calc_q  <= crc_cur;
      end
      unique case (state_q)
        CHK_IDLE, CHK_BODY: begin
          if (pay_acc) begin
            hd_q    <= s_data;
            hv_q    <= 1'b1;
            wcnt_q  <= wcnt_q + CW'(1);
            state_q <= hit_max ? CHK_FLUSH : CHK_BODY;
          end else if (trl_acc) begin
            hv_q    <= 1'b0;
            wcnt_q  <= '0;
            state_q <= CHK_IDLE;
          end
        end
        CHK_FLUSH: begin
          if (m_ready) begin
            hv_q    <= 1'b0;
            state_q <= CHK_DROP;
          end
        end
        CHK_DROP: begin
          if (drop_end) begin
            wcnt_q  <= '0;
            state_q <= CHK_IDLE;
          end
        end
        default: state_q <= CHK_IDLE;
      endcase
    end
  end

  assign stat_valid    = stat_valid_q;
  assign stat_crc_ok   = stat_ok_q;
  assign stat_overrun  = stat_ov_q;
  assign stat_crc_recv = stat_recv_q;
  assign stat_crc_calc = stat_calc_q;

`ifdef CRC32_FRAME_STATS_EN
  logic [31:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (stat_evt) begin
      if (frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (!stat_ok_d && err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Randomised self-checking bench for crc32_frame_checker against a bit-serial CRC reference model.
module tb_crc32_frame_checker;

  localparam int unsigned TB_MAX = 16;
  localparam logic [31:0] POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] INIT   = 32'hFFFF_FFFF;
  localparam int          TMO    = 2000;

  typedef logic [31:0] wq_t[$];

  logic        clk, rst;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last, m_ready;
  logic        stat_valid, stat_crc_ok, stat_overrun;
  logic [31:0] stat_crc_recv, stat_crc_calc;
`ifdef CRC32_FRAME_STATS_EN
  logic [31:0] frame_cnt, err_cnt;
  int          n_frames, n_bad;
`endif

  int          n_chk, n_err, n_tmo;
  logic [32:0] exp_m[$];
  logic [65:0] exp_st[$];
  logic        rdy_mode, rdy_fix, gaps;

  crc32_frame_checker #(.MAX_WORDS(TB_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .stat_valid   (stat_valid),
    .stat_crc_ok  (stat_crc_ok),
    .stat_overrun (stat_overrun),
    .stat_crc_recv(stat_crc_recv),
    .stat_crc_calc(stat_crc_calc)
`ifdef CRC32_FRAME_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC: each data bit, MSB first, is folded into the feedback tap.
  function automatic logic [31:0] model_crc(input wq_t w, input int n);
    logic [31:0] c;
    logic        fb;
    c = INIT;
    for (int i = 0; i < n; i++) begin
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ w[i][b];
        c  = c << 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end
  end

  initial begin
    logic [32:0] e;
    logic [65:0] s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_valid && m_ready) begin
          chk("m_expected", 32'(exp_m.size() != 0), 32'd1);
          if (exp_m.size() != 0) begin
            e = exp_m.pop_front();
            chk("m_data", m_data, e[31:0]);
            chk("m_last", 32'(m_last), 32'(e[32]));
          end
        end
        if (stat_valid) begin
          chk("stat_expected", 32'(exp_st.size() != 0), 32'd1);
          if (exp_st.size() != 0) begin
            s = exp_st.pop_front();
            chk("stat_crc_ok", 32'(stat_crc_ok), 32'(s[65]));
            chk("stat_overrun", 32'(stat_overrun), 32'(s[64]));
            chk("stat_crc_recv", stat_crc_recv, s[63:32]);
            chk("stat_crc_calc", stat_crc_calc, s[31:0]);
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    while (gaps && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      s_last  = $urandom_range(0, 1) == 1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > TMO) begin
        n_tmo++;
        $display("FAIL s_ready_wait got=stalled exp=accept");
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input wq_t w, input logic [31:0] trl);
    int          n, k;
    logic [31:0] c;
    logic        ok;
    n = w.size();
    k = (n >= int'(TB_MAX)) ? int'(TB_MAX) : n;
    c = model_crc(w, k);
    for (int i = 0; i < k; i++) exp_m.push_back({(i == k - 1), w[i]});
    ok = (n < int'(TB_MAX)) && (trl == c);
    exp_st.push_back({ok, (n >= int'(TB_MAX)), trl, c});
`ifdef CRC32_FRAME_STATS_EN
    n_frames++;
    if (!ok) n_bad++;
`endif
    for (int i = 0; i < n; i++) send_beat(w[i], 1'b0);
    send_beat(trl, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_m.size() != 0 || exp_st.size() != 0) && n < TMO) begin
      @(posedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_tmo++;
      $display("FAIL drain got=pending exp=empty");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame(input int len, input bit good);
    wq_t w;
    for (int i = 0; i < len; i++) w.push_back($urandom);
    send_frame(w, good ? model_crc(w, len) : $urandom);
  endtask

  initial begin
    wq_t         w;
    logic [31:0] t;
    n_chk = 0; n_err = 0; n_tmo = 0;
    rdy_mode = 1'b0; rdy_fix = 1'b1; gaps = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
`ifdef CRC32_FRAME_STATS_EN
    n_frames = 0; n_bad = 0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_stat_valid", 32'(stat_valid), 32'd0);
    chk("rst_stat_ok", 32'(stat_crc_ok), 32'd0);
    chk("rst_stat_ov", 32'(stat_overrun), 32'd0);
    chk("rst_stat_recv", stat_crc_recv, 32'd0);
    chk("rst_stat_calc", stat_crc_calc, 32'd0);
`ifdef CRC32_FRAME_STATS_EN
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Empty frame, then the three-word frame good and with a flipped trailer bit.
    w = {};
    send_frame(w, 32'hFFFF_FFFF);
    w = {32'h0000_0001, 32'hDEAD_BEEF, 32'h1234_5678};
    t = model_crc(w, 3);
    send_frame(w, t);
    send_frame(w, t ^ 32'd1);
    drain();

    // Length boundaries around MAX_WORDS, and recovery after an overrun.
    rand_frame(TB_MAX - 1, 1'b1);
    rand_frame(TB_MAX, 1'b1);
    rand_frame(TB_MAX + 2, 1'b1);
    rand_frame(5, 1'b1);
    drain();

    rdy_mode = 1'b1;
    gaps     = 1'b1;
    for (int f = 0; f < 50; f++) begin
      rand_frame($urandom_range(1, 20), $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset mid-frame with a word held and presented.
    rdy_mode = 1'b0;
    rdy_fix  = 1'b1;
    gaps     = 1'b0;
    @(posedge clk);
    #1;
    w = {32'hA5A5_0001, 32'hA5A5_0002};
    exp_m.push_back({1'b0, w[0]});
    send_beat(w[0], 1'b0);
    send_beat(w[1], 1'b0);
    rdy_fix = 1'b0;
    @(posedge clk);
    #2;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0003;
    s_last  = 1'b0;
    #1;
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rdy_fix = 1'b1;
    repeat (8) @(posedge clk);
    #1;
`ifdef CRC32_FRAME_STATS_EN
    chk("post_rst_frame_cnt", frame_cnt, 32'd0);
    chk("post_rst_err_cnt", err_cnt, 32'd0);
    n_frames = 0;
    n_bad    = 0;
`endif
    rand_frame(7, 1'b1);
    rand_frame(3, 1'b0);
    drain();

    chk("m_left", 32'(exp_m.size()), 32'd0);
    chk("stat_left", 32'(exp_st.size()), 32'd0);
    chk("timeouts", 32'(n_tmo), 32'd0);
`ifdef CRC32_FRAME_STATS_EN
    chk("frame_cnt", frame_cnt, 32'(n_frames));
    chk("err_cnt", err_cnt, 32'(n_bad));
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
